// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the MA stage (master) and data memory (slave).
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// RV32I memory-access stage: runs data-memory transactions with lane steering and load
// extension, registers the write-back result, and reports misaligned/illegal/timeout faults.
module memory_access #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_ld_ma,
    input  logic                   cmd_st_ma,
    input  logic                   wbk_rd_reg_ma,
    input  logic [4:0]             rd_adr_ma,
    input  logic [31:0]            rd_data_ma,
    input  logic [31:0]            st_data_ma,
    input  logic [2:0]             ldst_code_ma,
    output logic                   stall_ma,
    memory_access_if.master        dmem,
    output logic                   wbk_rd_reg_wb,
    output logic [4:0]             rd_adr_wb,
    output logic [31:0]            rd_data_wb,
    output logic                   ma_excep,
    output logic [3:0]             ma_excep_code,
    output logic [31:0]            ma_excep_adr
);

    localparam int unsigned CntW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [29:0]     adr_q, adr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wb_vld_q, wb_vld_d;
    logic [4:0]      wb_adr_q, wb_adr_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            excep_q, excep_d;
    logic [3:0]      excep_code_q, excep_code_d;
    logic [31:0]     excep_adr_q, excep_adr_d;

    logic        is_mem, is_st, illegal, misalign, timeout, wb_vld_ma;
    logic [1:0]  lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Both ld and st set is handled as a store.
    always_comb begin
        is_st     = cmd_st_ma;
        is_mem    = cmd_ld_ma | cmd_st_ma;
        lane      = rd_data_ma[1:0];
        wb_vld_ma = wbk_rd_reg_ma & (rd_adr_ma != 5'd0);
        if (is_st) begin
            illegal = ldst_code_ma[2] | (ldst_code_ma[1:0] == 2'b11);
        end else begin
            illegal = (ldst_code_ma[1:0] == 2'b11) | (ldst_code_ma[2:1] == 2'b11);
        end
        misalign = ~illegal & (((ldst_code_ma[1:0] == 2'b10) & (lane != 2'b00)) |
                               ((ldst_code_ma[1:0] == 2'b01) & lane[0]));
        timeout  = (TMO_CYCLES != 0) && (cnt_q == TmoLast);
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = st_data_ma;
        unique case (ldst_code_ma[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << lane;
                wdata_calc = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                be_calc    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{st_data_ma[15:0]}};
            end
            default: ;
        endcase
    end

    // Upstream holds the MA inputs during the wait, so the live offset/funct3 are still valid.
    always_comb begin
        ld_byte = dmem.dmem_rdata[8*lane +: 8];
        ld_half = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (ldst_code_ma)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        adr_d        = adr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        wb_vld_d     = 1'b0;
        wb_adr_d     = wb_adr_q;
        wb_data_d    = wb_data_q;
        excep_d      = 1'b0;
        excep_code_d = excep_code_q;
        excep_adr_d  = excep_adr_q;
        stall_ma     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mem) begin
                    if (illegal | misalign) begin
                        excep_d      = 1'b1;
                        excep_code_d = is_st ? (illegal ? 4'd7 : 4'd6) : (illegal ? 4'd5 : 4'd4);
                        excep_adr_d  = rd_data_ma;
                    end else begin
                        stall_ma = 1'b1;
                        state_d  = StWait;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = is_st;
                        adr_d    = rd_data_ma[31:2];
                        be_d     = be_calc;
                        wdata_d  = is_st ? wdata_calc : 32'd0;
                    end
                end else begin
                    wb_vld_d  = wb_vld_ma;
                    wb_adr_d  = rd_adr_ma;
                    wb_data_d = rd_data_ma;
                end
            end
            StWait: begin
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                    if (!we_q) begin
                        wb_vld_d  = wb_vld_ma;
                        wb_adr_d  = rd_adr_ma;
                        wb_data_d = ld_ext;
                    end
                end else if (timeout) begin
                    req_d        = 1'b0;
                    state_d      = StIdle;
                    excep_d      = 1'b1;
                    excep_code_d = we_q ? 4'd7 : 4'd5;
                    excep_adr_d  = rd_data_ma;
                end else begin
                    stall_ma = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            wb_vld_q     <= 1'b0;
            wb_adr_q     <= '0;
            wb_data_q    <= '0;
            excep_q      <= 1'b0;
            excep_code_q <= '0;
            excep_adr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wb_vld_q     <= wb_vld_d;
            wb_adr_q     <= wb_adr_d;
            wb_data_q    <= wb_data_d;
            excep_q      <= excep_d;
            excep_code_q <= excep_code_d;
            excep_adr_q  <= excep_adr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_adr   = adr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wbk_rd_reg_wb   = wb_vld_q;
    assign rd_adr_wb       = wb_adr_q;
    assign rd_data_wb      = wb_data_q;
    assign ma_excep        = excep_q;
    assign ma_excep_code   = excep_code_q;
    assign ma_excep_adr    = excep_adr_q;

endmodule
